// File: rtl/serial_readout_shifter.sv
// Serial readout stage: fetches one bank of {ts, ch} records and shifts them out
// MSB-first on rising edges of an oversampled external readout clock.
`timescale 1ns/1ps
module serial_readout_shifter #(
  parameter int TS_W   = 16,
  parameter int CH_W   = 7,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   readout_clk_pin,
  input  logic                   bank_ready,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [TS_W+CH_W-1:0]   rd_data,
  output logic                   serial_out,
  output logic                   serial_readout,
  output logic                   sending_data,
  output logic                   sending_pending,
  output logic                   bank_released,
  output logic                   overrun
);

  localparam int W     = TS_W + CH_W;
  localparam int CNT_W = $clog2(W);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_SHIFT, S_STOP, S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [2:0]         sync_reg;
  logic               tick_reg;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [W-1:0]       shift_reg, shift_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               out_reg, out_next;
  logic               data_reg, data_next;
  logic               frame_reg, frame_next;
  logic               pending_reg, pending_next;
  logic               overrun_reg, overrun_next;

  // sync_reg[1:0] is the 2-FF synchroniser, sync_reg[2] the edge register;
  // the tick is registered so the FSM acts 3 clk after the pin is first sampled high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= '0;
      tick_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[1:0], readout_clk_pin};
      tick_reg <= sync_reg[1] & ~sync_reg[2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      addr_reg    <= '0;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      out_reg     <= 1'b0;
      data_reg    <= 1'b0;
      frame_reg   <= 1'b0;
      pending_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      shift_reg   <= shift_next;
      cnt_reg     <= cnt_next;
      out_reg     <= out_next;
      data_reg    <= data_next;
      frame_reg   <= frame_next;
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    shift_next   = shift_reg;
    cnt_next     = cnt_reg;
    out_next     = out_reg;
    data_next    = data_reg;
    frame_next   = frame_reg;
    pending_next = pending_reg;
    overrun_next = overrun_reg;

    // Only one request can queue behind the running frame.
    if (bank_ready && (state_reg != S_IDLE)) begin
      if (pending_reg) overrun_next = 1'b1;
      else             pending_next = 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (bank_ready) begin
          addr_next  = '0;
          state_next = S_FETCH;
        end
      end
      S_FETCH: state_next = S_LOAD;
      S_LOAD: begin
        shift_next = rd_data;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (tick_reg) begin
          out_next   = 1'b1;
          data_next  = 1'b0;
          frame_next = 1'b1;
          cnt_next   = '0;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (tick_reg) begin
          out_next   = shift_reg[W-1];
          shift_next = {shift_reg[W-2:0], 1'b0};
          data_next  = 1'b1;
          cnt_next   = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(W-1)) begin
            if (addr_reg < ADDR_W'(DEPTH-1)) begin
              addr_next  = addr_reg + ADDR_W'(1);
              state_next = S_FETCH;
            end else begin
              state_next = S_STOP;
            end
          end
        end
      end
      S_STOP: begin
        if (tick_reg) begin
          out_next   = 1'b0;
          data_next  = 1'b0;
          frame_next = 1'b0;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        addr_next = '0;
        // A bank_ready arriving in this very cycle counts as the pending request.
        if (pending_reg || bank_ready) begin
          pending_next = 1'b0;
          state_next   = S_FETCH;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign rd_addr         = addr_reg;
  assign serial_out      = out_reg;
  assign serial_readout  = frame_reg;
  assign sending_data    = data_reg;
  assign sending_pending = pending_reg;
  assign bank_released   = (state_reg == S_DONE);
  assign overrun         = overrun_reg;

endmodule

// File: tb/tb_serial_readout_shifter.sv
// Randomised scoreboard bench: frames are predicted as bit lists when bank_ready
// is issued; a pin-driven monitor pops and compares every emitted bit.
`timescale 1ns/1ps
module tb_serial_readout_shifter;
  localparam int TS_W = 16, CH_W = 7, DEPTH = 8, ADDR_W = 3;
  localparam int W = TS_W + CH_W;

  logic clk = 1'b0, rst_n = 1'b0, pin = 1'b0, bank_ready = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  logic [W-1:0]      rd_data;
  logic serial_out, serial_readout, sending_data, sending_pending, bank_released, overrun;

  serial_readout_shifter #(.TS_W(TS_W), .CH_W(CH_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .readout_clk_pin(pin), .bank_ready(bank_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .serial_out(serial_out),
    .serial_readout(serial_readout), .sending_data(sending_data),
    .sending_pending(sending_pending), .bank_released(bank_released), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Bank memory with one-cycle registered read.
  logic [W-1:0] mem [DEPTH];
  always @(posedge clk) rd_data <= mem[rd_addr];

  typedef struct packed { logic b; logic d; logic stop; } exp_t;
  exp_t exp_q[$];

  int checks = 0, passes = 0;
  int frames_started = 0, frames_aborted = 0, frames_done = 0;
  int bits_seen = 0, rel_cnt = 0;
  logic exp_overrun = 1'b0;
  int half = 5;
  bit pin_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  always @(negedge clk) if (bank_released) rel_cnt++;

  initial forever begin
    @(negedge clk);
    if (pin_en) begin
      pin = 1'b1;
      repeat (half) @(negedge clk);
      pin = 1'b0;
      repeat (half - 1) @(negedge clk);
    end
  end

  // Reference: a frame is DEPTH words of {1, record MSB..LSB} then a single 0.
  task automatic push_frame();
    for (int w = 0; w < DEPTH; w++) begin
      exp_q.push_back('{b: 1'b1, d: 1'b0, stop: 1'b0});
      for (int b = W - 1; b >= 0; b--) exp_q.push_back('{b: mem[w][b], d: 1'b1, stop: 1'b0});
    end
    exp_q.push_back('{b: 1'b0, d: 1'b0, stop: 1'b1});
  endtask

  // Monitor: each pin rise must leave serial_out untouched for 3 clk, then present one bit.
  initial begin
    logic v0, r0, stable, emitted;
    exp_t e;
    forever begin
      @(posedge pin);
      v0 = serial_out; r0 = serial_readout; stable = 1'b1;
      repeat (3) begin
        @(posedge clk); #1;
        if (serial_out !== v0) stable = 1'b0;
      end
      @(posedge clk); #1;
      check("latency_hold", stable, 1'b1);
      emitted = serial_readout | r0;
      if (!emitted) begin
        check("idle_hold", serial_out, v0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_bit", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        bits_seen++;
        $display("bit %0d: serial_out=%0b sending_data=%0b", bits_seen, serial_out, sending_data);
        check("serial_out", serial_out, e.b);
        check("sending_data", sending_data, e.d);
        if (e.stop) begin
          repeat (3) @(negedge clk);
          frames_done++;
          check("bank_released_count", rel_cnt, frames_done);
        end
      end
    end
  end

  task automatic issue_ready();
    int n;
    @(negedge clk);
    n = frames_started - frames_done - frames_aborted;
    if (n < 2) begin
      push_frame();
      frames_started++;
      n++;
    end else begin
      exp_overrun = 1'b1;
    end
    bank_ready = 1'b1;
    @(negedge clk);
    bank_ready = 1'b0;
    $display("bank_ready issued: outstanding=%0d pending=%0b overrun=%0b", n, sending_pending, overrun);
    check("sending_pending", sending_pending, (n == 2));
    check("overrun", overrun, exp_overrun);
  endtask

  task automatic wait_bits(input int target);
    int t = 0;
    while (bits_seen < target && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) check("wait_bits_timeout", bits_seen, target);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || frames_started - frames_aborted != frames_done) && t < 6000) begin
      @(negedge clk); t++;
    end
    if (t >= 6000) check("frame_timeout", exp_q.size(), 0);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_serial_out"}, serial_out, 1'b0);
    check({tag, "_serial_readout"}, serial_readout, 1'b0);
    check({tag, "_sending_data"}, sending_data, 1'b0);
    check({tag, "_sending_pending"}, sending_pending, 1'b0);
    check({tag, "_bank_released"}, bank_released, 1'b0);
    check({tag, "_overrun"}, overrun, 1'b0);
    check({tag, "_rd_addr"}, rd_addr, 0);
  endtask

  initial begin
    int base;
    for (int i = 0; i < DEPTH; i++) mem[i] = {16'(i * 'h1111), 7'(i)};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    // Single bank, pin period 10; first rise arrives while waiting for the first start bit.
    half = 5;
    issue_ready();
    repeat (4) @(negedge clk);
    pin_en = 1'b1;
    wait_idle();

    // Back-to-back: second request during word 3.
    randomize_mem();
    base = bits_seen;
    issue_ready();
    wait_bits(base + 3 * (W + 1) + 5);
    issue_ready();
    wait_idle();
    check("no_overrun", overrun, 1'b0);

    // Overrun: three more requests during one frame -> two frames total.
    randomize_mem();
    base = bits_seen;
    issue_ready();
    wait_bits(base + 30);
    repeat (3) begin issue_ready(); repeat (3) @(negedge clk); end
    wait_idle();
    check("overrun_sticky", overrun, 1'b1);

    // Minimum pin period 8.
    pin_en = 1'b0;
    repeat (20) @(negedge clk);
    half = 4;
    pin_en = 1'b1;
    randomize_mem();
    issue_ready();
    wait_idle();

    // Reset mid-SHIFT, then restart from record 0.
    randomize_mem();
    base = bits_seen;
    issue_ready();
    wait_bits(base + 50);
    pin_en = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("midreset");
    rst_n = 1'b1;
    exp_q.delete();
    frames_aborted++;
    exp_overrun = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_release", rel_cnt, frames_done);
    randomize_mem();
    issue_ready();
    pin_en = 1'b1;
    wait_idle();

    pin_en = 1'b0;
    repeat (30) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("final_pending", sending_pending, 1'b0);
    check("final_overrun", overrun, exp_overrun);
    check("final_readout", serial_readout, 1'b0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1, "watchdog");
  end
endmodule
